// File: rtl/id_issue_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module  : id_issue_ctrl_pkg
// Purpose : Shared encodings for the ID-stage issue sequencer. This package
//           holds the immediate-type selects, the RV32IM opcode and funct
//           constants, the sequencer state encodings and the NOP word.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package id_issue_ctrl_pkg;

    // Immediate-format selects that feed the ID immediate generator (bits [2:0]).
    localparam logic [2:0] IMM_TYPE1 = 3'd1;   // U-type
    localparam logic [2:0] IMM_TYPE2 = 3'd2;   // J-type
    localparam logic [2:0] IMM_TYPE3 = 3'd3;   // I-type
    localparam logic [2:0] IMM_TYPE4 = 3'd4;   // B-type
    localparam logic [2:0] IMM_TYPE5 = 3'd5;   // S-type
    localparam logic [2:0] IMM_TYPE6 = 3'd6;   // shift-amount

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
    localparam logic [2:0] FUNCT3_SLLI   = 3'b001;
    localparam logic [2:0] FUNCT3_SRXI   = 3'b101;  // SRLI and SRAI

    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_DIV_BUSY = 1'b1;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;  // addi x0,x0,0

endpackage

`default_nettype wire

// File: rtl/id_issue_ctrl_imm_sel_decode.sv
//------------------------------------------------------------------------------
// Module  : imm_sel_decode
// Purpose : Combinational pre-decode of a fetched instruction. It produces
//           the immediate select, a divide flag and an rs2-usage flag.
// Ports   : i_inst      - instruction word
//           o_imm_sel   - {zero-extend, IMM_TYPE}
//           o_is_div    - DIV/DIVU/REM/REMU
//           o_uses_rs2  - instruction reads rs2 (BRANCH, STORE, OP)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module imm_sel_decode
    import id_issue_ctrl_pkg::*;
(
    input  logic [31:0] i_inst,
    output logic [3:0]  o_imm_sel,
    output logic        o_is_div,
    output logic        o_uses_rs2
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;

    assign w_opcode = i_inst[6:0];
    assign w_funct3 = i_inst[14:12];
    assign w_funct7 = i_inst[31:25];

    // Register and immediate fields are not needed for pre-decode.
    logic w_unused_bits;
    assign w_unused_bits = ^{i_inst[24:15], i_inst[11:7]};

    always_comb begin
        o_imm_sel  = {1'b0, IMM_TYPE3};
        o_is_div   = 1'b0;
        o_uses_rs2 = 1'b0;
        case (w_opcode)
            OP_LUI, OP_AUIPC: o_imm_sel = {1'b0, IMM_TYPE1};
            OP_JAL:           o_imm_sel = {1'b0, IMM_TYPE2};
            OP_JALR, OP_LOAD: o_imm_sel = {1'b0, IMM_TYPE3};
            OP_BRANCH: begin
                o_imm_sel  = {1'b0, IMM_TYPE4};
                o_uses_rs2 = 1'b1;
            end
            OP_STORE: begin
                o_imm_sel  = {1'b0, IMM_TYPE5};
                o_uses_rs2 = 1'b1;
            end
            OP_IMM: begin
                if (w_funct3 == FUNCT3_SLLI || w_funct3 == FUNCT3_SRXI)
                    o_imm_sel = {1'b0, IMM_TYPE6};
            end
            OP_OP: begin
                o_uses_rs2 = 1'b1;
                // funct3[2] set selects the divide/remainder half of the M group.
                o_is_div   = (w_funct7 == FUNCT7_MULDIV) && w_funct3[2];
            end
            default: o_imm_sel = {1'b0, IMM_TYPE3};
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/id_issue_ctrl.sv
//------------------------------------------------------------------------------
// Module  : id_issue_ctrl
// Purpose : ID-stage issue sequencer. It holds the IF/ID instruction
//           register and pre-decodes the immediate select. It issues to EX
//           under valid/ready, inserts load-use bubbles, and blocks issue
//           while a multi-cycle divide occupies EX.
// Ports   : CLK, RESET (async, active-high)
//           if_valid/if_inst/if_pc/if_ready - fetch handshake
//           flush                           - redirect, squashes ID
//           ex_mem_read/ex_rd/ex_ready      - EX status
//           issue_valid, id_inst, id_pc, id_imm_sel, id_is_div - to EX
//           div_busy                        - divide occupies EX
// Config  : ID_PERF_CNT_EN adds the perf_haz_cnt and perf_div_cnt outputs.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module id_issue_ctrl
    import id_issue_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = 34,
    parameter int CNT_W      = 6
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        if_valid,
    input  logic [31:0] if_inst,
    input  logic [31:0] if_pc,
    output logic        if_ready,
    input  logic        flush,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        ex_ready,
    output logic        issue_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [3:0]  id_imm_sel,
    output logic        id_is_div,
    output logic        div_busy
`ifdef ID_PERF_CNT_EN
    ,
    output logic [31:0] perf_haz_cnt,
    output logic [31:0] perf_div_cnt
`endif
);

    localparam logic [CNT_W-1:0] c_div_load = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_div_cnt;
    logic             r_id_valid;
    logic [31:0]      r_id_inst;
    logic [31:0]      r_id_pc;
    logic [3:0]       r_id_imm_sel;
    logic             r_id_is_div;
    logic             r_id_uses_rs2;

    logic [3:0] w_dec_imm_sel;
    logic       w_dec_is_div;
    logic       w_dec_uses_rs2;
    logic       w_run;
    logic       w_hazard;
    logic       w_fire;
    logic       w_load;

    // Decode happens ahead of the ID register so that id_imm_sel is registered.
    imm_sel_decode u_dec (
        .i_inst     (if_inst),
        .o_imm_sel  (w_dec_imm_sel),
        .o_is_div   (w_dec_is_div),
        .o_uses_rs2 (w_dec_uses_rs2)
    );

    assign w_run    = (r_state == ST_RUN);
    assign w_hazard = r_id_valid && ex_mem_read && (ex_rd != 5'd0) &&
                      ((ex_rd == r_id_inst[19:15]) ||
                       ((ex_rd == r_id_inst[24:20]) && r_id_uses_rs2));

    assign issue_valid = r_id_valid && w_run && !w_hazard && !flush;
    assign w_fire      = issue_valid && ex_ready;
    assign if_ready    = w_run && !w_hazard && (!r_id_valid || w_fire);
    assign w_load      = if_valid && if_ready && !flush;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state       <= ST_RUN;
            r_div_cnt     <= '0;
            r_id_valid    <= 1'b0;
            r_id_inst     <= NOP_INST;
            r_id_pc       <= '0;
            r_id_imm_sel  <= '0;
            r_id_is_div   <= 1'b0;
            r_id_uses_rs2 <= 1'b0;
        end else if (flush) begin
            r_state    <= ST_RUN;
            r_div_cnt  <= '0;
            r_id_valid <= 1'b0;
        end else begin
            if (w_load) begin
                r_id_valid    <= 1'b1;
                r_id_inst     <= if_inst;
                r_id_pc       <= if_pc;
                r_id_imm_sel  <= w_dec_imm_sel;
                r_id_is_div   <= w_dec_is_div;
                r_id_uses_rs2 <= w_dec_uses_rs2;
            end else if (w_fire) begin
                r_id_valid <= 1'b0;
            end

            case (r_state)
                ST_RUN: begin
                    if (w_fire && r_id_is_div) begin
                        r_state   <= ST_DIV_BUSY;
                        r_div_cnt <= c_div_load;
                    end
                end
                ST_DIV_BUSY: begin
                    // Leaving on count 1 makes the next issue DIV_CYCLES after the fire.
                    if (r_div_cnt == c_cnt_one) begin
                        r_state   <= ST_RUN;
                        r_div_cnt <= '0;
                    end else begin
                        r_div_cnt <= r_div_cnt - c_cnt_one;
                    end
                end
                default: begin
                    r_state   <= ST_RUN;
                    r_div_cnt <= '0;
                end
            endcase
        end
    end

    assign id_inst    = r_id_inst;
    assign id_pc      = r_id_pc;
    assign id_imm_sel = r_id_imm_sel;
    assign id_is_div  = r_id_is_div;
    assign div_busy   = (r_state == ST_DIV_BUSY);

`ifdef ID_PERF_CNT_EN
    logic [31:0] r_perf_haz_cnt;
    logic [31:0] r_perf_div_cnt;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_perf_haz_cnt <= '0;
            r_perf_div_cnt <= '0;
        end else begin
            if (w_hazard && w_run && !flush)
                r_perf_haz_cnt <= r_perf_haz_cnt + 32'd1;
            if (!w_run)
                r_perf_div_cnt <= r_perf_div_cnt + 32'd1;
        end
    end

    assign perf_haz_cnt = r_perf_haz_cnt;
    assign perf_div_cnt = r_perf_div_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_issue_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_id_issue_ctrl
// Purpose : Self-checking bench for id_issue_ctrl. It applies directed and
//           randomized stimulus against a cycle-index reference model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_id_issue_ctrl;

    localparam int DIV_CYCLES = 34;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK;
    logic        RESET;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        flush;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic        ex_ready;
    logic        issue_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic [3:0]  id_imm_sel;
    logic        id_is_div;
    logic        div_busy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: the ID slot and the first cycle at which issue is allowed again.
    bit          m_valid;
    logic [31:0] m_inst;
    logic [31:0] m_pc;
    int          m_block_until;
    int          cyc;

    id_issue_ctrl #(.DIV_CYCLES(DIV_CYCLES), .CNT_W(6)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .if_valid    (if_valid),
        .if_inst     (if_inst),
        .if_pc       (if_pc),
        .if_ready    (if_ready),
        .flush       (flush),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .ex_ready    (ex_ready),
        .issue_valid (issue_valid),
        .id_inst     (id_inst),
        .id_pc       (id_pc),
        .id_imm_sel  (id_imm_sel),
        .id_is_div   (id_is_div),
        .div_busy    (div_busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [3:0] ref_sel(input logic [31:0] i);
        case (i[6:0])
            7'h37, 7'h17: return 4'd1;
            7'h6F:        return 4'd2;
            7'h63:        return 4'd4;
            7'h23:        return 4'd5;
            7'h13:        return (i[14:12] == 3'd1 || i[14:12] == 3'd5) ? 4'd6 : 4'd3;
            default:      return 4'd3;
        endcase
    endfunction

    function automatic bit ref_div(input logic [31:0] i);
        return (i[6:0] == 7'h33) && (i[31:25] == 7'd1) && (i[14:12] >= 3'd4);
    endfunction

    function automatic bit ref_rs2(input logic [31:0] i);
        return (i[6:0] == 7'h33) || (i[6:0] == 7'h63) || (i[6:0] == 7'h23);
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [4:0] rd, r1, r2;
        logic [2:0] f3;
        rd = 5'($urandom_range(0, 7));
        r1 = 5'($urandom_range(0, 7));
        r2 = 5'($urandom_range(0, 7));
        f3 = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 9))
            0: return {12'($urandom), r1, f3, rd, 7'h13};          // OP-IMM incl. shifts
            1: return {7'd0, r2, r1, f3, rd, 7'h33};               // OP
            2: return {7'd1, r2, r1, f3, rd, 7'h33};               // M ext (mul/div)
            3: return {12'($urandom), r1, 3'd2, rd, 7'h03};        // load
            4: return {7'($urandom), r2, r1, 3'd2, 5'($urandom), 7'h23};
            5: return {7'($urandom), r2, r1, 3'd0, 5'($urandom), 7'h63};
            6: return {20'($urandom), rd, 7'h37};
            7: return {20'($urandom), rd, 7'h6F};
            8: return {12'($urandom), r1, 3'd0, rd, 7'h67};
            default: return $urandom;
        endcase
    endfunction

    task automatic model_reset();
        m_valid       = 1'b0;
        m_inst        = NOP;
        m_pc          = 32'd0;
        m_block_until = 0;
    endtask

    // One clock cycle: drive, check against the model, clock, advance the model.
    task automatic step(input logic iv, input logic [31:0] inst, input logic [31:0] pc,
                        input logic fl, input logic emr, input logic [4:0] erd,
                        input logic er);
        bit busy, haz, exp_iv, exp_rdy, fire, load;
        if_valid    = iv;
        if_inst     = inst;
        if_pc       = pc;
        flush       = fl;
        ex_mem_read = emr;
        ex_rd       = erd;
        ex_ready    = er;
        #2;
        busy    = (cyc < m_block_until);
        haz     = m_valid && emr && (erd != 5'd0) &&
                  ((erd == m_inst[19:15]) || ((erd == m_inst[24:20]) && ref_rs2(m_inst)));
        exp_iv  = m_valid && !busy && !haz && !fl;
        exp_rdy = !busy && !haz && (!m_valid || (exp_iv && er));
        check("issue_valid", 32'(issue_valid), 32'(exp_iv));
        check("if_ready", 32'(if_ready), 32'(exp_rdy));
        check("div_busy", 32'(div_busy), 32'(busy));
        if (m_valid) begin
            check("id_inst", id_inst, m_inst);
            check("id_pc", id_pc, m_pc);
            check("id_imm_sel", 32'(id_imm_sel), 32'(ref_sel(m_inst)));
            check("id_is_div", 32'(id_is_div), 32'(ref_div(m_inst)));
        end
        fire = exp_iv && er;
        load = iv && exp_rdy && !fl;
        @(posedge CLK);
        if (fl) begin
            m_valid       = 1'b0;
            m_block_until = 0;
        end else begin
            if (fire && ref_div(m_inst))
                m_block_until = cyc + DIV_CYCLES;
            if (load) begin
                m_valid = 1'b1;
                m_inst  = inst;
                m_pc    = pc;
            end else if (fire) begin
                m_valid = 1'b0;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic rand_steps(input int n, input int flush_pct);
        for (int k = 0; k < n; k++)
            step($urandom_range(0, 99) < 70, rand_inst(), $urandom,
                 $urandom_range(0, 99) < flush_pct, $urandom_range(0, 99) < 30,
                 5'($urandom_range(0, 7)), $urandom_range(0, 99) < 75);
    endtask

    localparam logic [31:0] I_ADDI = 32'h0050_0093;  // addi x1,x0,5
    localparam logic [31:0] I_SW   = 32'h0011_2423;  // sw x1,8(x2)
    localparam logic [31:0] I_ADD  = 32'h0072_8333;  // add x6,x5,x7
    localparam logic [31:0] I_BEQ  = 32'h0000_0063;  // beq x0,x0,0
    localparam logic [31:0] I_DIV  = 32'h0252_41B3;  // div x3,x4,x5

    initial begin
        RESET = 1'b1; if_valid = 0; if_inst = 0; if_pc = 0;
        flush = 0; ex_mem_read = 0; ex_rd = 0; ex_ready = 0;
        cyc = 0;
        model_reset();
        #12;
        check("rst_issue_valid", 32'(issue_valid), 32'd0);
        check("rst_div_busy", 32'(div_busy), 32'd0);
        check("rst_id_inst", id_inst, NOP);
        check("rst_id_pc", id_pc, 32'd0);
        check("rst_id_imm_sel", 32'(id_imm_sel), 32'd0);
        check("rst_id_is_div", 32'(id_is_div), 32'd0);
        @(posedge CLK); #1;
        RESET = 1'b0;

        // Stream, load-use bubble, stalled branch, divide occupancy.
        step(1, I_ADDI, 32'h100, 0, 0, 0, 1);
        step(1, I_SW,   32'h104, 0, 0, 0, 1);
        step(1, I_ADD,  32'h108, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 5'd5, 1);
        step(0, 0, 0, 0, 0, 5'd5, 1);
        step(1, I_BEQ,  32'h10C, 0, 0, 0, 1);
        for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        step(1, I_DIV,  32'h110, 0, 0, 0, 1);
        step(1, I_ADDI, 32'h114, 0, 0, 0, 1);
        for (int k = 0; k < DIV_CYCLES + 2; k++) step(0, 0, 0, 0, 0, 0, 1);
        // Flush with a concurrent fetch and EX stalled drops the fetch.
        step(1, I_SW,   32'h200, 0, 0, 0, 0);
        step(1, I_ADD,  32'h204, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);

        rand_steps(2000, 5);
        rand_steps(600, 0);

        // Asynchronous reset in the middle of a divide.
        step(0, 0, 0, 1, 0, 0, 1);
        step(1, I_DIV, 32'h300, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 0, 1);
        RESET = 1'b1;
        #1;
        check("mid_rst_issue_valid", 32'(issue_valid), 32'd0);
        check("mid_rst_id_inst", id_inst, NOP);
        check("mid_rst_div_busy", 32'(div_busy), 32'd0);
        model_reset();
        @(posedge CLK); #1;
        RESET = 1'b0;
        rand_steps(300, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
